// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Used by fetch_stage and, with FETCH_PERF_EN, its perf counters.
package fetch_pkg;

    localparam int DEFAULT_ADDR_W = 9;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        EMPTY  = 1'b0,
        STREAM = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
    } if_id_t;

endpackage

// File: rtl/sat_counter.sv
// 16-bit saturating event counter with increment enable.
// Instantiated by fetch_stage when FETCH_PERF_EN is defined.
module sat_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, sync-read imem address, IF/ID register.
// Optional FETCH_PERF_EN adds fetch_cnt / bubble_cnt outputs.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic              ifid_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       bubble_cnt
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] infl_q, infl_d;
    logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
    if_id_t            ifid_q, ifid_d;
    logic              load_valid;
    logic              load_bubble;

    // Re-issuing the in-flight address keeps imem_rdata stable while stalled
    assign imem_addr  = stall ? infl_q : pc_q;
    assign ifid_instr = ifid_q.instr;
    assign ifid_valid = ifid_q.valid;
    assign ifid_pc    = ifid_pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= EMPTY;
            pc_q      <= RESET_PC;
            infl_q    <= '0;
            ifid_pc_q <= '0;
            ifid_q    <= '{valid: 1'b0, instr: NOP_INSTR};
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            ifid_pc_q <= ifid_pc_d;
            ifid_q    <= ifid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        infl_d      = infl_q;
        ifid_pc_d   = ifid_pc_q;
        ifid_d      = ifid_q;
        load_valid  = 1'b0;
        load_bubble = 1'b0;
        priority case (1'b1)
            redirect: begin
                pc_d        = redirect_target;
                state_d     = EMPTY;
                ifid_d      = '{valid: 1'b0, instr: NOP_INSTR};
                load_bubble = 1'b1;
            end
            stall: begin
            end
            default: begin
                ifid_d.valid = (state_q == STREAM);
                ifid_d.instr = (state_q == STREAM) ? imem_rdata : NOP_INSTR;
                ifid_pc_d    = infl_q;
                infl_d       = pc_q;
                pc_d         = ADDR_W'(pc_q + 1'b1);
                state_d      = STREAM;
                load_valid   = (state_q == STREAM);
                load_bubble  = (state_q != STREAM);
            end
        endcase
    end

`ifdef FETCH_PERF_EN
    sat_counter u_fetch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (load_valid),
        .count (fetch_cnt)
    );

    sat_counter u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (load_bubble),
        .count (bubble_cnt)
    );
`else
    logic unused_perf;
    assign unused_perf = load_valid ^ load_bubble;
`endif

endmodule
